// File: rtl/uart_rx_interface_pkg.sv
// Shared definitions for the UART receive path: RX state encoding and sizing helpers.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_rx_interface_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_t;

    // Clocks per oversample tick. Clamped to 1 so a very fast link still ticks every clock.
    function automatic int calc_tick_div(input int clk_freq, input int baud_rate, input int oversample);
        int div;
        div = clk_freq / (baud_rate * oversample);
        return (div < 1) ? 1 : div;
    endfunction

    // Bits needed to hold 0..n-1, never less than 1.
    function automatic int calc_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_interface_if.sv
// Receive-side signal bundle: serial line in, received word and status out.
// Latency: n/a (wires only).
// Backpressure: none; o_rx_done is a strobe the consumer must catch.
//   master : the receiver (consumes i_uart_rx, drives the result signals)
//   slave  : the line driver / word consumer
interface uart_rx_interface_if #(
    parameter int DATA_BITS = 8
);
    logic                 i_uart_rx;
    logic [DATA_BITS-1:0] o_data;
    logic                 o_rx_done;
    logic                 o_frame_err;
    logic                 o_busy;

    modport master (
        input  i_uart_rx,
        output o_data, o_rx_done, o_frame_err, o_busy
    );

    modport slave (
        output i_uart_rx,
        input  o_data, o_rx_done, o_frame_err, o_busy
    );
endinterface

// File: rtl/uart_baud_tick_gen.sv
// Free-running divider producing a 1-clk o_tick every TICK_DIV clocks (OVERSAMPLE x baud).
// Latency: first tick TICK_DIV clocks after reset release; tick is registered.
// Backpressure: none; runs continuously. Ports: clk, reset (async high), o_tick.
module uart_baud_tick_gen
    import uart_rx_interface_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);
    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int CW       = calc_width(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + 1'b1;
            r_tick <= w_wrap;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/uart_rx_interface.sv
// 8N1-style UART receiver: 2-FF synchroniser, tick-driven FSM, LSB-first shift register.
// Latency: o_rx_done ~ (1.5 + DATA_BITS) bit times after the start edge (+2 clk sync, +1 tick).
// Backpressure: none; each word is presented with a single-clock o_rx_done strobe.
//   Ports: clk, reset (async high), rx_bus (master modport: i_uart_rx in; o_data,
//   o_rx_done, o_frame_err, o_busy out).
module uart_rx_interface
    import uart_rx_interface_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_rx_interface_if.master  rx_bus
);
    localparam int TW = calc_width(OVERSAMPLE);
    localparam int BW = calc_width(DATA_BITS);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

    logic                 w_tick;
    logic                 r_sync1, r_sync2;
    logic                 w_rx_s;
    rx_state_t            r_state,    w_state_nxt;
    logic [TW-1:0]        r_tick_cnt, w_tick_cnt_nxt;
    logic [BW-1:0]        r_bit_cnt,  w_bit_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic                 r_armed,    w_armed_nxt;
    logic [DATA_BITS-1:0] r_data,     w_data_nxt;
    logic                 r_done,     w_done_nxt;
    logic                 r_frame_err, w_frame_err_nxt;
    logic [DATA_BITS:0]   w_shift_wide;

    uart_baud_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

    assign w_rx_s = r_sync2;

    // New sample enters at the MSB, so after DATA_BITS shifts the first bit sits at bit 0.
    assign w_shift_wide = {w_rx_s, r_shift};

    always_comb begin
        w_state_nxt     = r_state;
        w_tick_cnt_nxt  = r_tick_cnt;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_shift_nxt     = r_shift;
        w_armed_nxt     = r_armed;
        w_data_nxt      = r_data;
        w_frame_err_nxt = r_frame_err;
        w_done_nxt      = 1'b0;

        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    // Only a high level seen on a tick arms the detector, so a held
                    // break after an errored frame cannot start a new one.
                    if (w_rx_s) begin
                        w_armed_nxt = 1'b1;
                    end else if (r_armed) begin
                        w_state_nxt    = ST_START;
                        w_tick_cnt_nxt = '0;
                    end
                end
                ST_START: begin
                    if (r_tick_cnt == T_HALF) begin
                        w_tick_cnt_nxt = '0;
                        if (!w_rx_s) begin
                            w_state_nxt   = ST_DATA;
                            w_bit_cnt_nxt = '0;
                        end else begin
                            // Line is high again: it was a glitch, and the high level re-arms.
                            w_state_nxt = ST_IDLE;
                            w_armed_nxt = 1'b1;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_tick_cnt == T_LAST) begin
                        w_tick_cnt_nxt = '0;
                        w_shift_nxt    = w_shift_wide[DATA_BITS:1];
                        if (r_bit_cnt == B_LAST) begin
                            w_state_nxt   = ST_STOP;
                            w_bit_cnt_nxt = '0;
                        end else begin
                            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_tick_cnt == T_LAST) begin
                        w_tick_cnt_nxt = '0;
                        w_done_nxt     = 1'b1;
                        w_state_nxt    = ST_IDLE;
                        // A good stop bit re-arms at once so back-to-back frames are caught.
                        w_armed_nxt    = w_rx_s;
                        if (w_rx_s) begin
                            w_data_nxt      = r_shift;
                            w_frame_err_nxt = 1'b0;
                        end else begin
                            w_frame_err_nxt = 1'b1;
                        end
                    end else begin
                        w_tick_cnt_nxt = r_tick_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_tick_cnt_nxt = '0;
                    w_bit_cnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_state     <= ST_IDLE;
            r_tick_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_armed     <= 1'b0;
            r_data      <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_sync1     <= rx_bus.i_uart_rx;
            r_sync2     <= r_sync1;
            r_state     <= w_state_nxt;
            r_tick_cnt  <= w_tick_cnt_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_armed     <= w_armed_nxt;
            r_data      <= w_data_nxt;
            r_done      <= w_done_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    assign rx_bus.o_data      = r_data;
    assign rx_bus.o_rx_done   = r_done;
    assign rx_bus.o_frame_err = r_frame_err;
    assign rx_bus.o_busy      = (r_state != ST_IDLE);

endmodule
